// File: rtl/note_sequencer.sv
// Scale-note sequencer: selects a divisor from an 8-entry ROM in manual or auto-play mode.
// Optional build macro NOTE_SEQ_DESCEND_EN makes auto-play ping-pong 0..7..0 instead of wrapping.
module note_sequencer #(
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000
) (
  input  logic        inclk,
  input  logic        Reset,
  input  logic        en,
  input  logic        play,
  input  logic [2:0]  sw,
  output logic [31:0] div_clk_count,
  output logic        mute,
  output logic [2:0]  note_idx,
  output logic        div_update
);

  typedef enum logic [1:0] {IDLE, MANUAL, PLAY, GAP} state_t;

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : 32'(GAP_CYCLES - 1);

  function automatic logic [31:0] rom(input logic [2:0] i);
    case (i)
      3'd0:    rom = 32'd47800;
      3'd1:    rom = 32'd42588;
      3'd2:    rom = 32'd37935;
      3'd3:    rom = 32'd35816;
      3'd4:    rom = 32'd31927;
      3'd5:    rom = 32'd28408;
      3'd6:    rom = 32'd25328;
      default: rom = 32'd23900;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        mute_q, mute_d;
  logic [31:0] div_q, div_d;
  logic        upd_q, upd_d;
  logic        advance;
  logic [2:0]  adv_idx;

`ifdef NOTE_SEQ_DESCEND_EN
  typedef enum logic {UP, DOWN} dir_t;
  dir_t dir_q, dir_d, adv_dir;

  // End notes play once: direction flips while stepping away from 7 or 0.
  always_comb begin
    adv_dir = dir_q;
    adv_idx = idx_q + 3'd1;
    if (dir_q == UP) begin
      if (idx_q == 3'd7) begin
        adv_dir = DOWN;
        adv_idx = 3'd6;
      end
    end else begin
      if (idx_q == 3'd0) begin
        adv_dir = UP;
        adv_idx = 3'd1;
      end else begin
        adv_idx = idx_q - 3'd1;
      end
    end
  end

  always_comb begin
    dir_d = dir_q;
    if (state_d == PLAY && (state_q == IDLE || state_q == MANUAL)) begin
      dir_d = UP;
    end else if (advance) begin
      dir_d = adv_dir;
    end
  end

  always_ff @(posedge inclk) begin
    if (Reset) begin
      dir_q <= UP;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  assign adv_idx = idx_q + 3'd1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    idx_d   = idx_q;
    advance = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, MANUAL: begin
          cnt_d = '0;
          if (play) begin
            state_d = PLAY;
            idx_d   = '0;
          end else begin
            state_d = MANUAL;
            idx_d   = sw;
          end
        end
        PLAY: begin
          if (!play) begin
            state_d = MANUAL;
            idx_d   = sw;
            cnt_d   = '0;
          end else if (cnt_q == NOTE_LAST) begin
            cnt_d = '0;
            if (GAP_CYCLES != 0) begin
              state_d = GAP;
            end else begin
              advance = 1'b1;
            end
          end
        end
        GAP: begin
          if (!play) begin
            state_d = MANUAL;
            idx_d   = sw;
            cnt_d   = '0;
          end else if (cnt_q == GAP_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
            advance = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    if (advance) begin
      idx_d = adv_idx;
    end
    // Outputs are computed from the next state so that every output is a register.
    mute_d = (state_d == IDLE) || (state_d == GAP);
    div_d  = rom(idx_d);
    upd_d  = (div_d != div_q);
  end

  always_ff @(posedge inclk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mute_q  <= 1'b1;
      div_q   <= 32'd47800;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mute_q  <= mute_d;
      div_q   <= div_d;
      upd_q   <= upd_d;
    end
  end

  assign div_clk_count = div_q;
  assign mute          = mute_q;
  assign note_idx      = idx_q;
  assign div_update    = upd_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: two instances (gap 2 and gap 0) share stimulus;
// expected divisor-change pulses are queued per instance and checked by a negedge monitor.
module tb_note_sequencer;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] div;
    logic        mute;
  } exp_t;

  logic        inclk = 1'b0;
  logic        Reset, en, play;
  logic [2:0]  sw;
  logic [31:0] o_div  [2];
  logic        o_mute [2];
  logic [2:0]  o_idx  [2];
  logic        o_upd  [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb [2][$];

  logic [31:0] ROM [8] = '{32'd47800, 32'd42588, 32'd37935, 32'd35816,
                           32'd31927, 32'd28408, 32'd25328, 32'd23900};
  string nm [2] = '{"g2", "g0"};

  note_sequencer #(.NOTE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .inclk(inclk), .Reset(Reset), .en(en), .play(play), .sw(sw),
    .div_clk_count(o_div[0]), .mute(o_mute[0]), .note_idx(o_idx[0]), .div_update(o_upd[0])
  );

  note_sequencer #(.NOTE_CYCLES(4), .GAP_CYCLES(0)) dutz (
    .inclk(inclk), .Reset(Reset), .en(en), .play(play), .sw(sw),
    .div_clk_count(o_div[1]), .mute(o_mute[1]), .note_idx(o_idx[1]), .div_update(o_upd[1])
  );

  always #5 inclk = ~inclk;
  always @(posedge inclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int seq_idx(input int n);
`ifdef NOTE_SEQ_DESCEND_EN
    int m;
    m = n % 14;
    return (m <= 7) ? m : 14 - m;
`else
    return n % 8;
`endif
  endfunction

  task automatic push(input int d, input int c, input int i);
    sb[d].push_back('{c, i, ROM[i], 1'b0});
  endtask

  task automatic push_both(input int c, input int i);
    push(0, c, i);
    push(1, c, i);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge inclk);
    #1;
  endtask

  // Monitor: every div_update pulse must match the oldest queued expectation.
  always @(negedge inclk) begin
    for (int unsigned d = 0; d < 2; d++) begin
      if (sb[d].size() > 0 && sb[d][0].cyc < cyc) begin
        chk({nm[d], "_pulse_missing_at"}, 32'(cyc), 32'(sb[d][0].cyc));
        void'(sb[d].pop_front());
      end
      if (o_upd[d] === 1'b1) begin
        if (sb[d].size() == 0) begin
          chk({nm[d], "_unexpected_pulse_idx"}, 32'(o_idx[d]), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb[d].pop_front();
          chk({nm[d], "_pulse_cycle"}, 32'(cyc), 32'(e.cyc));
          chk({nm[d], "_pulse_idx"}, 32'(o_idx[d]), 32'(e.idx));
          chk({nm[d], "_pulse_div"}, o_div[d], e.div);
          chk({nm[d], "_pulse_mute"}, 32'(o_mute[d]), 32'(e.mute));
        end
      end
    end
  end

  task automatic en_drop_round(input int d_off);
    int p;
    en = 1'b1; play = 1'b0; sw = 3'd3;
    push_both(cyc + 1, 3);
    step(2);
    play = 1'b1;
    push_both(cyc + 1, 0);
    p = cyc + 1;
    step(1 + d_off);
    chk("g2_mute_before_drop", 32'(o_mute[0]), 32'd0);
    en = 1'b0;
    step(1);
    @(negedge inclk);
    for (int unsigned d = 0; d < 2; d++) begin
      chk({nm[d], "_drop_mute"}, 32'(o_mute[d]), 32'd1);
      chk({nm[d], "_drop_idx_held"}, 32'(o_idx[d]), 32'd0);
    end
    if (cyc != p + d_off + 1) begin
      chk("drop_round_timing", 32'(cyc), 32'(p + d_off + 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int p;
    Reset = 1'b1; en = 1'b1; play = 1'b0; sw = 3'd0;
    step(3);
    @(negedge inclk);
    for (int unsigned d = 0; d < 2; d++) begin
      chk({nm[d], "_rst_div"}, o_div[d], 32'd47800);
      chk({nm[d], "_rst_idx"}, 32'(o_idx[d]), 32'd0);
      chk({nm[d], "_rst_mute"}, 32'(o_mute[d]), 32'd1);
      chk({nm[d], "_rst_upd"}, 32'(o_upd[d]), 32'd0);
    end
    Reset = 1'b0;
    step(1);
    @(negedge inclk);
    for (int unsigned d = 0; d < 2; d++) begin
      chk({nm[d], "_rel_mute"}, 32'(o_mute[d]), 32'd0);
      chk({nm[d], "_rel_div"}, o_div[d], 32'd47800);
    end

    // Manual selection, including a same-value rewrite that must not pulse.
    sw = 3'd5; push_both(cyc + 1, 5); step(3);
    sw = 3'd5; step(3);
    sw = 3'd2; push_both(cyc + 1, 2); step(2);
    sw = 3'd7; push_both(cyc + 1, 7); step(3);

    // Auto-play: gap 2 -> change every 6 cycles, gap 0 -> every 4 cycles.
    k = cyc;
    play = 1'b1;
    push_both(k + 1, 0);
    for (int n = 1; n <= 8; n++)  push(0, k + 1 + 6 * n, seq_idx(n));
    for (int n = 1; n <= 12; n++) push(1, k + 1 + 4 * n, seq_idx(n));
    for (int c = 1; c <= 50; c++) begin
      step(1);
      @(negedge inclk);
      chk("g2_auto_mute", 32'(o_mute[0]), ((cyc - k - 1) % 6 >= 4) ? 32'd1 : 32'd0);
      chk("g0_auto_mute", 32'(o_mute[1]), 32'd0);
    end
    en = 1'b0;
    step(1);
    @(negedge inclk);
    chk("g2_idle_mute", 32'(o_mute[0]), 32'd1);
    chk("g0_idle_mute", 32'(o_mute[1]), 32'd1);
    chk("g2_idle_idx", 32'(o_idx[0]), 32'(seq_idx(8)));
    chk("g0_idle_idx", 32'(o_idx[1]), 32'(seq_idx(12)));

    // en drop at cycle 2 of a note, then on the terminal count.
    en_drop_round(2);
    en_drop_round(3);

    // Reset while the gap-2 instance is in GAP.
    en = 1'b1; play = 1'b1;
    p = cyc + 1;
    push(0, p + 6, seq_idx(1));
    push(1, p + 4, seq_idx(1));
    push(1, p + 8, seq_idx(2));
    step(11);
    @(negedge inclk);
    chk("g2_in_gap_mute", 32'(o_mute[0]), 32'd1);
    Reset = 1'b1;
    step(1);
    @(negedge inclk);
    for (int unsigned d = 0; d < 2; d++) begin
      chk({nm[d], "_midrst_idx"}, 32'(o_idx[d]), 32'd0);
      chk({nm[d], "_midrst_mute"}, 32'(o_mute[d]), 32'd1);
      chk({nm[d], "_midrst_div"}, o_div[d], 32'd47800);
      chk({nm[d], "_midrst_upd"}, 32'(o_upd[d]), 32'd0);
    end

    // Leaving auto-play mid-note takes the switch value immediately.
    Reset = 1'b0;
    step(2);
    play = 1'b0; sw = 3'd3;
    push_both(cyc + 1, 3);
    step(1);
    @(negedge inclk);
    for (int unsigned d = 0; d < 2; d++) begin
      chk({nm[d], "_exit_idx"}, 32'(o_idx[d]), 32'd3);
      chk({nm[d], "_exit_mute"}, 32'(o_mute[d]), 32'd0);
    end
    step(4);
    @(negedge inclk);
    for (int unsigned d = 0; d < 2; d++) begin
      chk({nm[d], "_sb_drained"}, 32'(sb[d].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
